// File: rtl/output_layer_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : output_layer_engine_if
// Description : Bus bundle for the output-layer engine. The engine owns the
//               "master" modport: it drives the hidden-RAM and weight-ROM
//               read addresses, the score-RAM write port and the status
//               outputs. The "slave" modport is the environment side, which
//               drives start and returns the read data one clock after the
//               address.
//   start    : begin a pass (sampled only while idle)
//   hid_addr : hidden RAM read address        hid_q : unsigned activation
//   wt_addr  : weight ROM read address        wt_q  : signed weight
//   out_we / out_addr / out_data : score RAM write port
//   busy / done / digit          : pass status and recognised digit
// Revision    : 1.0 - initial release
// ============================================================================
interface output_layer_engine_if;
    logic       start;
    logic [4:0] hid_addr;
    logic [7:0] hid_q;
    logic [8:0] wt_addr;
    logic [7:0] wt_q;
    logic       out_we;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [3:0] digit;

    modport master (
        input  start, hid_q, wt_q,
        output hid_addr, wt_addr, out_we, out_addr, out_data, busy, done, digit
    );

    modport slave (
        output start, hid_q, wt_q,
        input  hid_addr, wt_addr, out_we, out_addr, out_data, busy, done, digit
    );
endinterface
`default_nettype wire

// File: rtl/output_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : output_layer_engine
// Description : Output-layer neuron sequencer. For each output neuron it
//               streams all hidden activations and matching weights, builds
//               the signed dot product, writes a saturated 8-bit score and
//               tracks the argmax, which is reported as the recognised digit.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - output_layer_engine_if.master (read addresses/data,
//                        score write port, busy/done/digit)
// Revision    : 1.0 - initial release
// ============================================================================
module output_layer_engine #(
    parameter int N_HID     = 32,
    parameter int N_OUT     = 10,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    output_layer_engine_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] c_K_LAST = 5'(N_HID - 1);
    localparam logic [3:0] c_N_LAST = 4'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-128);

    state_t                   state_q,   state_d;
    logic [3:0]               n_q,       n_d;
    logic [4:0]               k_q,       k_d;
    logic                     rd_vld_q;
    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic signed [ACC_W-1:0]  max_val_q, max_val_d;
    logic [3:0]               max_idx_q, max_idx_d;
    logic [3:0]               digit_q,   digit_d;

    logic signed [16:0]       w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [7:0]               w_sat;

    // Hidden activations are unsigned: a zero MSB keeps them positive in the
    // signed 9x8 multiply, giving a 17-bit signed product.
    assign w_prod     = $signed({1'b0, bus.hid_q}) * $signed(bus.wt_q);
    assign w_prod_ext = {{(ACC_W-17){w_prod[16]}}, w_prod};
    assign w_shifted  = acc_q >>> OUT_SHIFT;

    always_comb begin
        w_sat = w_shifted[7:0];
        if (w_shifted > c_SAT_MAX) begin
            w_sat = 8'h7F;
        end else if (w_shifted < c_SAT_MIN) begin
            w_sat = 8'h80;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            rd_vld_q  <= 1'b0;
            acc_q     <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            digit_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            // Read data lags the address by one clock, so the MAC enable is
            // the MAC state delayed by one clock.
            rd_vld_q  <= (state_q == S_MAC);
            acc_q     <= acc_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            digit_q   <= digit_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_d     = acc_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        digit_d   = digit_q;

        if (rd_vld_q) begin
            acc_d = acc_q + w_prod_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_MAC;
                    n_d     = '0;
                    k_d     = '0;
                end
            end
            S_MAC: begin
                if (k_q == c_K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            // One extra clock lets the last product land in the accumulator.
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_d = '0;
                // Strict compare keeps the lowest index on ties.
                if ((n_q == 4'd0) || (acc_q > max_val_q)) begin
                    max_val_d = acc_q;
                    max_idx_d = n_q;
                end
                if (n_q == c_N_LAST) begin
                    state_d = S_DONE;
                    n_d     = '0;
                end else begin
                    state_d = S_MAC;
                    n_d     = n_q + 4'd1;
                    k_d     = '0;
                end
            end
            S_DONE: begin
                digit_d = max_idx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.hid_addr = (state_q == S_MAC) ? k_q : 5'd0;
    assign bus.wt_addr  = (state_q == S_MAC) ?
                          (9'(n_q) * 9'(N_HID) + 9'(k_q)) : 9'd0;
    assign bus.out_we   = (state_q == S_WRITE);
    assign bus.out_addr = (state_q == S_WRITE) ? n_q   : 4'd0;
    assign bus.out_data = (state_q == S_WRITE) ? w_sat : 8'd0;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.digit    = digit_q;

endmodule
`default_nettype wire

// File: tb/tb_output_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_layer_engine
// Description : Self-checking bench for output_layer_engine. Hidden RAM and
//               weight ROM are modelled as one-clock-latency arrays; every
//               pass is compared against a dot-product/argmax reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_layer_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    output_layer_engine_if bus();

    output_layer_engine #(
        .N_HID(32), .N_OUT(10), .ACC_W(24), .OUT_SHIFT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] hid_mem [32];
    logic [7:0] wt_mem  [320];

    always @(posedge clk) begin
        bus.hid_q <= hid_mem[bus.hid_addr];
        bus.wt_q  <= wt_mem[bus.wt_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (bus.out_we === 1'b1) begin
            wr_addr_q.push_back(int'(bus.out_addr));
            wr_data_q.push_back(int'($signed(bus.out_data)));
            wr_cyc_q.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int checks = 0;
    int failures = 0;
    int exp_score [10];
    int exp_digit;

    // Reference: plain dot products, floor shift, clamp, first-max argmax.
    task automatic compute_model();
        int accs [10];
        int sh;
        for (int n = 0; n < 10; n++) begin
            accs[n] = 0;
            for (int k = 0; k < 32; k++)
                accs[n] += int'(hid_mem[k]) * int'($signed(wt_mem[n*32+k]));
            sh = accs[n] >>> 8;
            exp_score[n] = (sh > 127) ? 127 : ((sh < -128) ? -128 : sh);
        end
        exp_digit = 0;
        for (int n = 1; n < 10; n++)
            if (accs[n] > accs[exp_digit]) exp_digit = n;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt = 0;
    endtask

    // Pulses start for one clock; s is the cycle number of the sampling edge.
    task automatic run_pass(output int s, output bit ok);
        clear_log();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s = cyc;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.hid_addr, bus.wt_addr, bus.out_we, bus.out_addr, bus.out_data,
             bus.busy, bus.done, bus.digit} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b digit=%0d haddr=%0d waddr=%0d, expected all 0",
                     bus.busy, bus.done, bus.out_we, bus.digit, bus.hid_addr, bus.wt_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_one_hot();
        int s; bit ok;
        for (int k = 0; k < 32; k++) hid_mem[k] = 8'd255;
        for (int i = 0; i < 320; i++) wt_mem[i] = (i / 32 == 3) ? 8'd1 : 8'd0;
        compute_model();
        run_pass(s, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL one_hot_done: no done within 400 clks, expected done"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] != i || wr_data_q[i] != exp_score[i]) begin
                failures++;
                $display("FAIL one_hot_score[%0d]: got %0d writes addr=%0d data=%0d, expected addr=%0d data=%0d",
                         i, wr_addr_q.size(), (i < wr_addr_q.size()) ? wr_addr_q[i] : -1,
                         (i < wr_data_q.size()) ? wr_data_q[i] : -999, i, exp_score[i]);
            end
        end
        checks++;
        if (bus.digit !== 4'd3) begin failures++; $display("FAIL one_hot_digit: got %0d, expected 3", bus.digit); end
    endtask

    task automatic test_mid_reset();
        int s; int nwr;
        clear_log();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s = cyc;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nwr = wr_addr_q.size();
        checks++;
        if ({bus.out_we, bus.done, bus.busy, bus.digit, bus.hid_addr, bus.wt_addr,
             bus.out_addr, bus.out_data} !== 35'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got busy=%b we=%b done=%b digit=%0d haddr=%0d waddr=%0d, expected all 0",
                     bus.busy, bus.out_we, bus.done, bus.digit, bus.hid_addr, bus.wt_addr);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != nwr || done_cnt != 0 || bus.busy !== 1'b0 || bus.digit !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset_abort: got writes=%0d done=%0d busy=%b digit=%0d, expected writes=%0d done=0 busy=0 digit=0",
                     wr_addr_q.size(), done_cnt, bus.busy, bus.digit, nwr);
        end
    endtask

    task automatic test_saturation();
        int s; bit ok;
        for (int k = 0; k < 32; k++) hid_mem[k] = 8'd255;
        for (int i = 0; i < 320; i++)
            wt_mem[i] = (i < 32) ? 8'h7F : ((i < 64) ? 8'h80 : 8'h00);
        compute_model();
        run_pass(s, ok);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] != i || wr_data_q[i] != exp_score[i]) begin
                failures++;
                $display("FAIL sat_score[%0d]: got %0d writes data=%0d, expected addr=%0d data=%0d",
                         i, wr_addr_q.size(), (i < wr_data_q.size()) ? wr_data_q[i] : -999, i, exp_score[i]);
            end
        end
        checks++;
        if (!ok || bus.digit !== 4'd0) begin
            failures++;
            $display("FAIL sat_digit: got done=%0b digit=%0d, expected done=1 digit=0", ok, bus.digit);
        end
    endtask

    task automatic test_zero_ties();
        int s; bit ok;
        for (int k = 0; k < 32; k++) hid_mem[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 320; i++) wt_mem[i] = 8'd0;
        // Leave a nonzero digit from a previous pass so the tie result matters.
        run_pass(s, ok);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] != i || wr_data_q[i] != 0) begin
                failures++;
                $display("FAIL zero_score[%0d]: got %0d writes data=%0d, expected addr=%0d data=0",
                         i, wr_addr_q.size(), (i < wr_data_q.size()) ? wr_data_q[i] : -999, i);
            end
        end
        checks++;
        if (!ok || bus.digit !== 4'd0) begin
            failures++;
            $display("FAIL zero_digit: got done=%0b digit=%0d, expected done=1 digit=0", ok, bus.digit);
        end
    endtask

    task automatic test_alignment();
        int s; bit ok;
        for (int k = 0; k < 32; k++) hid_mem[k] = 8'(k);
        for (int i = 0; i < 320; i++)
            wt_mem[i] = (i / 32 == 7) ? (((i % 2) == 0) ? 8'd2 : 8'hFF) : 8'd0;
        compute_model();
        run_pass(s, ok);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] != i || wr_data_q[i] != exp_score[i]) begin
                failures++;
                $display("FAIL align_score[%0d]: got %0d writes data=%0d, expected addr=%0d data=%0d",
                         i, wr_addr_q.size(), (i < wr_data_q.size()) ? wr_data_q[i] : -999, i, exp_score[i]);
            end
        end
        checks++;
        if (!ok || bus.digit !== 4'd7) begin
            failures++;
            $display("FAIL align_digit: got done=%0b digit=%0d, expected done=1 digit=7", ok, bus.digit);
        end
    endtask

    task automatic test_start_held();
        int s; bit seen;
        for (int k = 0; k < 32; k++) hid_mem[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 320; i++) wt_mem[i] = 8'($urandom_range(0, 255));
        clear_log();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        s = cyc;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
        end
        // Start stays high through the DONE cycle, then drops while idle.
        @(negedge clk);
        checks++;
        if (!seen || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL held_busy_fall: got done_seen=%0b busy=%b, expected 1 and 0", seen, bus.busy);
        end
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt != 1 || (done_cyc - s) != 340) begin
            failures++;
            $display("FAIL held_done: got count=%0d at edge %0d, expected count=1 at edge 340",
                     done_cnt, done_cyc - s);
        end
        checks++;
        if (wr_cyc_q.size() != 10) begin
            failures++;
            $display("FAIL held_writes: got %0d writes, expected 10", wr_cyc_q.size());
        end
        for (int i = 0; i < 10 && i < wr_cyc_q.size(); i++) begin
            checks++;
            if (wr_cyc_q[i] - s + 1 != 34 * (i + 1)) begin
                failures++;
                $display("FAIL held_we_edge[%0d]: got write at edge %0d, expected %0d",
                         i, wr_cyc_q[i] - s + 1, 34 * (i + 1));
            end
        end
    endtask

    task automatic test_random();
        int s; bit ok;
        for (int iter = 0; iter < 4; iter++) begin
            for (int k = 0; k < 32; k++) hid_mem[k] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 320; i++)
                wt_mem[i] = (iter % 2 == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($signed($urandom_range(0, 15)) - 8);
            compute_model();
            run_pass(s, ok);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (i >= wr_addr_q.size() || wr_addr_q[i] != i || wr_data_q[i] != exp_score[i]) begin
                    failures++;
                    $display("FAIL rand%0d_score[%0d]: got %0d writes data=%0d, expected addr=%0d data=%0d",
                             iter, i, wr_addr_q.size(), (i < wr_data_q.size()) ? wr_data_q[i] : -999,
                             i, exp_score[i]);
                end
            end
            checks++;
            if (!ok || int'(bus.digit) != exp_digit) begin
                failures++;
                $display("FAIL rand%0d_digit: got done=%0b digit=%0d, expected done=1 digit=%0d",
                         iter, ok, bus.digit, exp_digit);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_one_hot();
        test_mid_reset();
        test_saturation();
        test_alignment();
        test_zero_ties();
        test_start_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
